mrv1_th_ctl: RTL and testbench

Thread-control unit sitting between the EXEC stage and the IMT scheduler (mrv1_th_sched).
- Accepts decoded TSPAWN and BARRIER ops from EXEC over a valid/ready handshake.
- Tracks barrier arrivals per barrier ID.
- Drives the scheduler's th_ctl_* interface, plus barrier stall and release notifications.
- It is the initiator side of the interface the scheduler receives.

---
 rtl/mrv1_th_ctl_pkg.sv | 30 +++
 rtl/mrv1_bar_table.sv | 72 +++++++
 rtl/mrv1_th_ctl.sv | 181 ++++++++++++++++++
 tb/tb_mrv1_th_ctl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mrv1_th_ctl_pkg.sv
// Shared types for the thread-control unit: op encoding, FSM states and barrier entry layout.
package mrv1_th_ctl_pkg;

  localparam int unsigned NUM_THREADS  = 8;
  localparam int unsigned PC_WIDTH     = 32;
  localparam int unsigned NUM_BARRIERS = 8;
  localparam int unsigned TID_WIDTH    = $clog2(NUM_THREADS);
  localparam int unsigned BAR_ID_WIDTH = $clog2(NUM_BARRIERS);
  localparam int unsigned CNT_WIDTH    = TID_WIDTH + 1;

  typedef enum logic [1:0] {
    RSVD0   = 2'd0,
    TSPAWN  = 2'd1,
    BARRIER = 2'd2,
    RSVD3   = 2'd3
  } th_ctl_op_e;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_SPAWN_WAIT = 1'b1
  } th_ctl_state_e;

  typedef struct packed {
    logic                   busy;
    logic [TID_WIDTH-1:0]   size_m1;
    logic [CNT_WIDTH-1:0]   count;
    logic [NUM_THREADS-1:0] mask;
  } bar_entry_t;

endpackage

// File: rtl/mrv1_bar_table.sv
// Barrier entry array: tracks arrivals per barrier ID and decides stall/release for each arrival.
module mrv1_bar_table
  import mrv1_th_ctl_pkg::*;
#(
  parameter int unsigned NUM_THREADS_P  = NUM_THREADS,
  parameter int unsigned NUM_BARRIERS_P = NUM_BARRIERS,
  localparam int unsigned TID_WIDTH_LP    = $clog2(NUM_THREADS_P),
  localparam int unsigned BAR_ID_WIDTH_LP = $clog2(NUM_BARRIERS_P),
  localparam int unsigned CNT_WIDTH_LP    = TID_WIDTH_LP + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       arr_vld_i,
  input  logic [TID_WIDTH_LP-1:0]    arr_tid_i,
  input  logic [BAR_ID_WIDTH_LP-1:0] arr_id_i,
  input  logic [TID_WIDTH_LP-1:0]    arr_size_m1_i,
  output logic [TID_WIDTH_LP-1:0]    size_m1_c,
  output logic                       stall_c,
  output logic                       release_c,
  output logic [NUM_THREADS_P-1:0]   release_mask_c,
  output logic                       dup_c,
  output logic                       size_err_c
);

  bar_entry_t entries_q [NUM_BARRIERS_P];
  bar_entry_t entries_d [NUM_BARRIERS_P];
  bar_entry_t cur;
  logic [NUM_THREADS_P-1:0] tid_bit;

  always_comb begin
    entries_d      = entries_q;
    stall_c        = 1'b0;
    release_c      = 1'b0;
    release_mask_c = '0;
    cur            = entries_q[arr_id_i];
    tid_bit        = NUM_THREADS_P'(1) << arr_tid_i;
    dup_c          = cur.busy && |(cur.mask & tid_bit);
    size_err_c     = cur.busy && (cur.size_m1 != arr_size_m1_i);
    size_m1_c      = cur.busy ? cur.size_m1 : arr_size_m1_i;

    // A duplicate arrival leaves the entry untouched.
    if (arr_vld_i && !dup_c) begin
      if (!cur.busy) begin
        if (arr_size_m1_i == '0) begin
          release_c      = 1'b1;
          release_mask_c = tid_bit;
        end else begin
          entries_d[arr_id_i] = '{busy: 1'b1, size_m1: arr_size_m1_i,
                                  count: CNT_WIDTH_LP'(1), mask: tid_bit};
          stall_c = 1'b1;
        end
      end else if (cur.count == CNT_WIDTH_LP'(cur.size_m1)) begin
        release_c           = 1'b1;
        release_mask_c      = cur.mask | tid_bit;
        entries_d[arr_id_i] = '0;
      end else begin
        entries_d[arr_id_i].count = cur.count + CNT_WIDTH_LP'(1);
        entries_d[arr_id_i].mask  = cur.mask | tid_bit;
        stall_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      entries_q <= '{default: '0};
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/mrv1_th_ctl.sv
// Thread-control unit: accepts TSPAWN/BARRIER ops from EXEC and drives the scheduler's th_ctl interface.
module mrv1_th_ctl
  import mrv1_th_ctl_pkg::*;
#(
  parameter int unsigned NUM_THREADS_P  = NUM_THREADS,
  parameter int unsigned PC_WIDTH_P     = PC_WIDTH,
  parameter int unsigned NUM_BARRIERS_P = NUM_BARRIERS,
  localparam int unsigned TID_WIDTH_LP    = $clog2(NUM_THREADS_P),
  localparam int unsigned BAR_ID_WIDTH_LP = $clog2(NUM_BARRIERS_P)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_vld_i,
  output logic                       req_rdy_o,
  input  logic [TID_WIDTH_LP-1:0]    req_tid_i,
  input  logic [1:0]                 req_op_i,
  input  logic [PC_WIDTH_P-1:0]      req_pc_i,
  input  logic [BAR_ID_WIDTH_LP-1:0] req_bar_id_i,
  input  logic [TID_WIDTH_LP-1:0]    req_bar_size_m1_i,
  input  logic [NUM_THREADS_P-1:0]   active_threads_i,
  output logic                       th_ctl_vld_o,
  output logic [TID_WIDTH_LP-1:0]    th_ctl_tid_o,
  output logic                       th_ctl_tspawn_vld_o,
  output logic [PC_WIDTH_P-1:0]      th_ctl_tspawn_pc_o,
  output logic                       th_ctl_barrier_vld_o,
  output logic [BAR_ID_WIDTH_LP-1:0] th_ctl_barrier_id_o,
  output logic [TID_WIDTH_LP-1:0]    th_ctl_barrier_size_m1_o,
  output logic                       bar_stall_vld_o,
  output logic [TID_WIDTH_LP-1:0]    bar_stall_tid_o,
  output logic                       bar_release_vld_o,
  output logic [NUM_THREADS_P-1:0]   bar_release_mask_o,
  output logic                       spawn_fail_o,
  output logic                       err_o
);

  th_ctl_state_e state_q, state_d;
  th_ctl_op_e    op;
  logic rdy_q, rdy_d, th_vld_q, th_vld_d, spawn_vld_q, spawn_vld_d;
  logic bar_vld_q, bar_vld_d, stall_vld_q, stall_vld_d, rel_vld_q, rel_vld_d;
  logic spawn_fail_q, spawn_fail_d, err_q, err_d;
  logic [TID_WIDTH_LP-1:0]    tid_q, tid_d, bar_size_q, bar_size_d, stall_tid_q, stall_tid_d;
  logic [PC_WIDTH_P-1:0]      pc_q, pc_d;
  logic [BAR_ID_WIDTH_LP-1:0] bar_id_q, bar_id_d;
  logic [NUM_THREADS_P-1:0]   rel_mask_q, rel_mask_d;

  logic                     accept;
  logic                     bar_arr;
  logic [TID_WIDTH_LP-1:0]  tbl_size_m1;
  logic                     tbl_stall, tbl_release, tbl_dup, tbl_size_err;
  logic [NUM_THREADS_P-1:0] tbl_release_mask;

  assign op      = th_ctl_op_e'(req_op_i);
  assign accept  = req_vld_i && rdy_q;
  assign bar_arr = accept && (op == BARRIER);

  mrv1_bar_table #(
    .NUM_THREADS_P  (NUM_THREADS_P),
    .NUM_BARRIERS_P (NUM_BARRIERS_P)
  ) u_bar_table (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .arr_vld_i      (bar_arr),
    .arr_tid_i      (req_tid_i),
    .arr_id_i       (req_bar_id_i),
    .arr_size_m1_i  (req_bar_size_m1_i),
    .size_m1_c      (tbl_size_m1),
    .stall_c        (tbl_stall),
    .release_c      (tbl_release),
    .release_mask_c (tbl_release_mask),
    .dup_c          (tbl_dup),
    .size_err_c     (tbl_size_err)
  );

  always_comb begin
    state_d      = state_q;
    rdy_d        = 1'b1;
    th_vld_d     = 1'b0;
    tid_d        = '0;
    spawn_vld_d  = 1'b0;
    pc_d         = '0;
    bar_vld_d    = 1'b0;
    bar_id_d     = '0;
    bar_size_d   = '0;
    stall_vld_d  = 1'b0;
    stall_tid_d  = '0;
    rel_vld_d    = 1'b0;
    rel_mask_d   = '0;
    spawn_fail_d = 1'b0;
    err_d        = err_q;

    if (state_q == ST_SPAWN_WAIT) begin
      state_d = ST_IDLE;
    end

    if (accept) begin
      unique case (op)
        TSPAWN: begin
          if (&active_threads_i) begin
            spawn_fail_d = 1'b1;
          end else begin
            th_vld_d    = 1'b1;
            tid_d       = req_tid_i;
            spawn_vld_d = 1'b1;
            pc_d        = req_pc_i;
            state_d     = ST_SPAWN_WAIT;
            rdy_d       = 1'b0;
          end
        end
        BARRIER: begin
          if (tbl_dup) begin
            err_d = 1'b1;
          end else begin
            th_vld_d    = 1'b1;
            tid_d       = req_tid_i;
            bar_vld_d   = 1'b1;
            bar_id_d    = req_bar_id_i;
            bar_size_d  = tbl_size_m1;
            stall_vld_d = tbl_stall;
            stall_tid_d = tbl_stall ? req_tid_i : '0;
            rel_vld_d   = tbl_release;
            rel_mask_d  = tbl_release_mask;
            err_d       = err_q | tbl_size_err;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      rdy_q        <= 1'b1;
      th_vld_q     <= 1'b0;
      tid_q        <= '0;
      spawn_vld_q  <= 1'b0;
      pc_q         <= '0;
      bar_vld_q    <= 1'b0;
      bar_id_q     <= '0;
      bar_size_q   <= '0;
      stall_vld_q  <= 1'b0;
      stall_tid_q  <= '0;
      rel_vld_q    <= 1'b0;
      rel_mask_q   <= '0;
      spawn_fail_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      th_vld_q     <= th_vld_d;
      tid_q        <= tid_d;
      spawn_vld_q  <= spawn_vld_d;
      pc_q         <= pc_d;
      bar_vld_q    <= bar_vld_d;
      bar_id_q     <= bar_id_d;
      bar_size_q   <= bar_size_d;
      stall_vld_q  <= stall_vld_d;
      stall_tid_q  <= stall_tid_d;
      rel_vld_q    <= rel_vld_d;
      rel_mask_q   <= rel_mask_d;
      spawn_fail_q <= spawn_fail_d;
      err_q        <= err_d;
    end
  end

  assign req_rdy_o                = rdy_q;
  assign th_ctl_vld_o             = th_vld_q;
  assign th_ctl_tid_o             = tid_q;
  assign th_ctl_tspawn_vld_o      = spawn_vld_q;
  assign th_ctl_tspawn_pc_o       = pc_q;
  assign th_ctl_barrier_vld_o     = bar_vld_q;
  assign th_ctl_barrier_id_o      = bar_id_q;
  assign th_ctl_barrier_size_m1_o = bar_size_q;
  assign bar_stall_vld_o          = stall_vld_q;
  assign bar_stall_tid_o          = stall_tid_q;
  assign bar_release_vld_o        = rel_vld_q;
  assign bar_release_mask_o       = rel_mask_q;
  assign spawn_fail_o             = spawn_fail_q;
  assign err_o                    = err_q;

endmodule

// File: tb/tb_mrv1_th_ctl.sv
// Directed bench for mrv1_th_ctl: a vector table of {inputs, expected outputs} plus short hand sequences.
module tb_mrv1_th_ctl;

  typedef struct packed {
    logic        rst_n;
    logic        vld;
    logic [1:0]  op;
    logic [2:0]  tid;
    logic [31:0] pc;
    logic [2:0]  bid;
    logic [2:0]  bsz;
    logic [7:0]  active;
  } in_t;

  typedef struct packed {
    logic        rdy;
    logic        th_vld;
    logic [2:0]  tid;
    logic        sp_vld;
    logic [31:0] pc;
    logic        bar_vld;
    logic [2:0]  bid;
    logic [2:0]  bsz;
    logic        st_vld;
    logic [2:0]  st_tid;
    logic        rel_vld;
    logic [7:0]  rel_mask;
    logic        sp_fail;
    logic        err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld, req_rdy;
  logic [2:0]  req_tid, req_bar_id, req_bar_size_m1;
  logic [1:0]  req_op;
  logic [31:0] req_pc;
  logic [7:0]  active;
  logic        th_vld, sp_vld, bar_vld, st_vld, rel_vld, sp_fail, err;
  logic [2:0]  th_tid, bar_id, bar_sz, st_tid;
  logic [31:0] sp_pc;
  logic [7:0]  rel_mask;

  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mrv1_th_ctl dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .req_vld_i                (req_vld),
    .req_rdy_o                (req_rdy),
    .req_tid_i                (req_tid),
    .req_op_i                 (req_op),
    .req_pc_i                 (req_pc),
    .req_bar_id_i             (req_bar_id),
    .req_bar_size_m1_i        (req_bar_size_m1),
    .active_threads_i         (active),
    .th_ctl_vld_o             (th_vld),
    .th_ctl_tid_o             (th_tid),
    .th_ctl_tspawn_vld_o      (sp_vld),
    .th_ctl_tspawn_pc_o       (sp_pc),
    .th_ctl_barrier_vld_o     (bar_vld),
    .th_ctl_barrier_id_o      (bar_id),
    .th_ctl_barrier_size_m1_o (bar_sz),
    .bar_stall_vld_o          (st_vld),
    .bar_stall_tid_o          (st_tid),
    .bar_release_vld_o        (rel_vld),
    .bar_release_mask_o       (rel_mask),
    .spawn_fail_o             (sp_fail),
    .err_o                    (err)
  );

  function automatic in_t i_rst();
    return '{rst_n: 1'b0, vld: 1'b0, op: 2'd0, tid: 3'd0, pc: 32'd0, bid: 3'd0, bsz: 3'd0, active: 8'h01};
  endfunction

  function automatic in_t i_idle();
    in_t r = i_rst();
    r.rst_n = 1'b1;
    return r;
  endfunction

  function automatic in_t i_op(input logic [1:0] op, input logic [2:0] tid);
    in_t r = i_idle();
    r.vld = 1'b1;
    r.op  = op;
    r.tid = tid;
    return r;
  endfunction

  function automatic in_t i_spawn(input logic [2:0] tid, input logic [31:0] pc, input logic [7:0] act);
    in_t r = i_op(2'd1, tid);
    r.pc     = pc;
    r.active = act;
    return r;
  endfunction

  function automatic in_t i_bar(input logic [2:0] tid, input logic [2:0] bid, input logic [2:0] bsz);
    in_t r = i_op(2'd2, tid);
    r.bid = bid;
    r.bsz = bsz;
    return r;
  endfunction

  function automatic out_t o_idle(input logic e);
    out_t r = '0;
    r.rdy = 1'b1;
    r.err = e;
    return r;
  endfunction

  function automatic out_t o_fail(input logic e);
    out_t r = o_idle(e);
    r.sp_fail = 1'b1;
    return r;
  endfunction

  function automatic out_t o_spawn(input logic [2:0] tid, input logic [31:0] pc, input logic e);
    out_t r = o_idle(e);
    r.rdy    = 1'b0;
    r.th_vld = 1'b1;
    r.tid    = tid;
    r.sp_vld = 1'b1;
    r.pc     = pc;
    return r;
  endfunction

  function automatic out_t o_bar(input logic [2:0] tid, input logic [2:0] bid, input logic [2:0] bsz,
                                 input logic stall, input logic rel, input logic [7:0] mask, input logic e);
    out_t r = o_idle(e);
    r.th_vld   = 1'b1;
    r.tid      = tid;
    r.bar_vld  = 1'b1;
    r.bid      = bid;
    r.bsz      = bsz;
    r.st_vld   = stall;
    r.st_tid   = stall ? tid : 3'd0;
    r.rel_vld  = rel;
    r.rel_mask = mask;
    return r;
  endfunction

  task automatic step(input in_t i, input out_t e, input string nm);
    out_t a;
    @(negedge clk);
    rst_n           = i.rst_n;
    req_vld         = i.vld;
    req_op          = i.op;
    req_tid         = i.tid;
    req_pc          = i.pc;
    req_bar_id      = i.bid;
    req_bar_size_m1 = i.bsz;
    active          = i.active;
    @(posedge clk);
    #1;
    a = {req_rdy, th_vld, th_tid, sp_vld, sp_pc, bar_vld, bar_id, bar_sz,
         st_vld, st_tid, rel_vld, rel_mask, sp_fail, err};
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  initial begin
    rst_n = 1'b0; req_vld = 1'b0; req_op = 2'd0; req_tid = 3'd0; req_pc = 32'd0;
    req_bar_id = 3'd0; req_bar_size_m1 = 3'd0; active = 8'h01;

    vecs.push_back('{i_rst(),                          o_idle(1'b0)});
    vecs.push_back('{i_spawn(3'd0, 32'h100, 8'h01),     o_spawn(3'd0, 32'h100, 1'b0)});
    vecs.push_back('{i_spawn(3'd2, 32'h200, 8'h03),     o_idle(1'b0)});  // offered while not ready
    vecs.push_back('{i_idle(),                          o_idle(1'b0)});
    vecs.push_back('{i_spawn(3'd1, 32'h300, 8'hFF),     o_fail(1'b0)});
    vecs.push_back('{i_idle(),                          o_idle(1'b0)});
    vecs.push_back('{i_bar(3'd0, 3'd3, 3'd2),           o_bar(3'd0, 3'd3, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0)});
    vecs.push_back('{i_bar(3'd1, 3'd3, 3'd2),           o_bar(3'd1, 3'd3, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0)});
    vecs.push_back('{i_bar(3'd2, 3'd3, 3'd2),           o_bar(3'd2, 3'd3, 3'd2, 1'b0, 1'b1, 8'h07, 1'b0)});
    vecs.push_back('{i_bar(3'd4, 3'd3, 3'd0),           o_bar(3'd4, 3'd3, 3'd0, 1'b0, 1'b1, 8'h10, 1'b0)});
    vecs.push_back('{i_bar(3'd5, 3'd0, 3'd0),           o_bar(3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 8'h20, 1'b0)});
    vecs.push_back('{i_bar(3'd1, 3'd2, 3'd3),           o_bar(3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0)});
    vecs.push_back('{i_bar(3'd1, 3'd2, 3'd3),           o_idle(1'b1)});
    vecs.push_back('{i_bar(3'd3, 3'd2, 3'd1),           o_bar(3'd3, 3'd2, 3'd3, 1'b1, 1'b0, 8'h00, 1'b1)});
    vecs.push_back('{i_idle(),                          o_idle(1'b1)});
    vecs.push_back('{i_op(2'd3, 3'd4),                  o_idle(1'b1)});
    vecs.push_back('{i_bar(3'd0, 3'd4, 3'd2),           o_bar(3'd0, 3'd4, 3'd2, 1'b1, 1'b0, 8'h00, 1'b1)});
    vecs.push_back('{i_bar(3'd1, 3'd4, 3'd2),           o_bar(3'd1, 3'd4, 3'd2, 1'b1, 1'b0, 8'h00, 1'b1)});
    vecs.push_back('{i_rst(),                           o_idle(1'b0)});
    vecs.push_back('{i_bar(3'd6, 3'd4, 3'd1),           o_bar(3'd6, 3'd4, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0)});
    vecs.push_back('{i_bar(3'd7, 3'd4, 3'd1),           o_bar(3'd7, 3'd4, 3'd1, 1'b0, 1'b1, 8'hC0, 1'b0)});
    vecs.push_back('{i_bar(3'd1, 3'd2, 3'd0),           o_bar(3'd1, 3'd2, 3'd0, 1'b0, 1'b1, 8'h02, 1'b0)});

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].i, vecs[k].o, $sformatf("vec%0d", k));
    end

    // Interleaved barriers on two IDs must not disturb each other.
    step(i_bar(3'd0, 3'd1, 3'd1), o_bar(3'd0, 3'd1, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0), "ilv_a");
    step(i_bar(3'd2, 3'd5, 3'd1), o_bar(3'd2, 3'd5, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0), "ilv_b");
    step(i_bar(3'd3, 3'd1, 3'd1), o_bar(3'd3, 3'd1, 3'd1, 1'b0, 1'b1, 8'h09, 1'b0), "ilv_c");
    step(i_bar(3'd4, 3'd5, 3'd1), o_bar(3'd4, 3'd5, 3'd1, 1'b0, 1'b1, 8'h14, 1'b0), "ilv_d");

    // Reserved op 0 raises the sticky error; a later spawn still works with error held.
    step(i_op(2'd0, 3'd0), o_idle(1'b1), "rsvd0");
    step(i_spawn(3'd3, 32'hDEAD_BEE0, 8'h7F), o_spawn(3'd3, 32'hDEAD_BEE0, 1'b1), "spawn_err");
    step(i_idle(), o_idle(1'b1), "spawn_rdy");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
